// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared instruction-class and FSM definitions for the hazard controller and its bench.
package pipeline_hazard_ctrl_pkg;

  localparam logic [2:0] INS_ID_RTYPE = 3'd0;
  localparam logic [2:0] INS_ID_LW    = 3'd1;

  typedef enum logic {
    StRun     = 1'b0,
    StMemWait = 1'b1
  } state_e;

  localparam logic [7:0]  WAIT_CNT_MAX = 8'hFF;
  localparam logic [15:0] STAT_MAX     = 16'hFFFF;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// Flags a load in EX whose destination feeds a source operand of the instruction in ID.
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic       uses_rt_id,
  input  logic [4:0] rt_ex,
  input  logic [2:0] ins_ex,
  output logic       load_use
);

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = (ins_ex == INS_ID_LW) && (rt_ex != 5'd0) &&
                    ((rt_ex == rs_id) || (uses_rt_id && (rt_ex == rt_id)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush controller: memory freeze FSM, branch/load-use/jump handling, statistics.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs_id,
  input  logic [4:0]  rt_id,
  input  logic        uses_rt_id,
  input  logic [4:0]  rt_ex,
  input  logic [2:0]  INS_ID_ex,
  input  logic        branch_taken_ex,
  input  logic        jump_id,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  input  logic        clr_stats,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_write,
  output logic        exmem_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        memwb_bubble,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count,
  output logic        mem_timeout,
  output logic        state
);

  localparam logic [7:0] TimeoutCnt = TIMEOUT[7:0];

  state_e      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        timeout_q, timeout_d;
  logic [15:0] stall_q, stall_d;
  logic [15:0] flush_q, flush_d;
  logic        load_use;
  logic        freeze;

  load_use_detect u_load_use_detect (
    .rs_id      (rs_id),
    .rt_id      (rt_id),
    .uses_rt_id (uses_rt_id),
    .rt_ex      (rt_ex),
    .ins_ex     (INS_ID_ex),
    .load_use   (load_use)
  );

  assign freeze = (((state_q == StRun) && dmem_req) || (state_q == StMemWait)) && !dmem_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StRun: begin
        if (dmem_req && !dmem_ready) begin
          state_d    = StMemWait;
          wait_cnt_d = 8'd1;
        end
      end
      StMemWait: begin
        if (dmem_ready) begin
          state_d = StRun;
        end else if (wait_cnt_q != WAIT_CNT_MAX) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    memwb_bubble = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
    end else if (freeze) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
    end else if (branch_taken_ex) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end else if (jump_id) begin
      ifid_flush = 1'b1;
    end
  end

  always_comb begin
    timeout_d = timeout_q || ((state_q == StMemWait) && (wait_cnt_q == TimeoutCnt));
    stall_d   = stall_q;
    flush_d   = flush_q;
    if (clr_stats) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (!pc_write && (stall_q != STAT_MAX)) stall_d = stall_q + 16'd1;
      if ((ifid_flush || idex_flush) && (flush_q != STAT_MAX)) flush_d = flush_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
  assign mem_timeout  = timeout_q;
  assign state        = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: vector table for the priority logic, hand sequences for freeze/timeout/reset.
module tb_pipeline_hazard_ctrl;
  import pipeline_hazard_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs_id, rt_id, rt_ex;
  logic        uses_rt_id;
  logic [2:0]  INS_ID_ex;
  logic        branch_taken_ex, jump_id, dmem_req, dmem_ready, clr_stats;
  logic        pc_write, ifid_write, idex_write, exmem_write;
  logic        ifid_flush, idex_flush, memwb_bubble;
  logic [15:0] stall_cycles, flush_count;
  logic        mem_timeout, state;

  int total = 0;
  int bad   = 0;
  int exp_stall, exp_flush;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic [4:0] rtx;
    logic [2:0] ins;
    logic       br;
    logic       jmp;
    logic       req;
    logic       rdy;
    logic [6:0] ctl;   // {pc,ifid_w,idex_w,exmem_w,ifid_fl,idex_fl,bubble}
    logic       st;
  } vec_t;

  vec_t tbl[13];

  pipeline_hazard_ctrl #(.TIMEOUT(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rs_id           (rs_id),
    .rt_id           (rt_id),
    .uses_rt_id      (uses_rt_id),
    .rt_ex           (rt_ex),
    .INS_ID_ex       (INS_ID_ex),
    .branch_taken_ex (branch_taken_ex),
    .jump_id         (jump_id),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .clr_stats       (clr_stats),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .idex_write      (idex_write),
    .exmem_write     (exmem_write),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .memwb_bubble    (memwb_bubble),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count),
    .mem_timeout     (mem_timeout),
    .state           (state)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ctl_now();
    return {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush, memwb_bubble};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    rs_id = 5'd0; rt_id = 5'd0; uses_rt_id = 1'b0; rt_ex = 5'd0; INS_ID_ex = INS_ID_RTYPE;
    branch_taken_ex = 1'b0; jump_id = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    clr_stats = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    rs_id = v.rs; rt_id = v.rt; uses_rt_id = v.uses_rt; rt_ex = v.rtx; INS_ID_ex = v.ins;
    branch_taken_ex = v.br; jump_id = v.jmp; dmem_req = v.req; dmem_ready = v.rdy;
  endtask

  initial begin
    //             rs    rt    u     rtx   ins           br    jmp   req   rdy   ctl          st
    tbl[0]  = '{5'd1, 5'd2, 1'b0, 5'd3, INS_ID_RTYPE, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1111000, 1'b0};
    tbl[1]  = '{5'd5, 5'd0, 1'b0, 5'd5, INS_ID_LW,    1'b0, 1'b0, 1'b0, 1'b0, 7'b0011010, 1'b0};
    tbl[2]  = '{5'd0, 5'd0, 1'b0, 5'd0, INS_ID_LW,    1'b0, 1'b0, 1'b0, 1'b0, 7'b1111000, 1'b0};
    tbl[3]  = '{5'd1, 5'd7, 1'b0, 5'd7, INS_ID_LW,    1'b0, 1'b0, 1'b0, 1'b0, 7'b1111000, 1'b0};
    tbl[4]  = '{5'd1, 5'd7, 1'b1, 5'd7, INS_ID_LW,    1'b0, 1'b0, 1'b0, 1'b0, 7'b0011010, 1'b0};
    tbl[5]  = '{5'd5, 5'd0, 1'b0, 5'd5, INS_ID_RTYPE, 1'b0, 1'b0, 1'b0, 1'b0, 7'b1111000, 1'b0};
    tbl[6]  = '{5'd1, 5'd2, 1'b1, 5'd3, INS_ID_RTYPE, 1'b0, 1'b1, 1'b0, 1'b0, 7'b1111100, 1'b0};
    tbl[7]  = '{5'd5, 5'd0, 1'b0, 5'd5, INS_ID_LW,    1'b0, 1'b1, 1'b0, 1'b0, 7'b0011010, 1'b0};
    tbl[8]  = '{5'd5, 5'd0, 1'b0, 5'd5, INS_ID_LW,    1'b1, 1'b1, 1'b0, 1'b0, 7'b1111110, 1'b0};
    tbl[9]  = '{5'd1, 5'd2, 1'b0, 5'd3, INS_ID_RTYPE, 1'b0, 1'b0, 1'b1, 1'b1, 7'b1111000, 1'b0};
    tbl[10] = '{5'd5, 5'd0, 1'b0, 5'd5, INS_ID_LW,    1'b1, 1'b0, 1'b1, 1'b0, 7'b0000001, 1'b0};
    tbl[11] = '{5'd1, 5'd2, 1'b0, 5'd3, INS_ID_RTYPE, 1'b0, 1'b1, 1'b1, 1'b1, 7'b1111100, 1'b1};
    tbl[12] = '{5'd3, 5'd9, 1'b1, 5'd9, INS_ID_LW,    1'b0, 1'b0, 1'b0, 1'b0, 7'b0011010, 1'b0};

    idle();
    rst_n = 1'b0;
    dmem_req = 1'b1; branch_taken_ex = 1'b1; jump_id = 1'b1;
    @(negedge clk); @(negedge clk);
    #1;
    chk("reset_ctl", 32'(ctl_now()), 32'h0);
    chk("reset_state", 32'(state), 32'h0);
    chk("reset_stall", 32'(stall_cycles), 32'h0);
    chk("reset_flush", 32'(flush_count), 32'h0);
    chk("reset_timeout", 32'(mem_timeout), 32'h0);

    @(negedge clk);
    idle();
    rst_n = 1'b1;

    exp_stall = 0;
    exp_flush = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      chk($sformatf("vec%0d_ctl", i), 32'(ctl_now()), 32'(tbl[i].ctl));
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].st));
      if (!tbl[i].ctl[6]) exp_stall++;
      if (tbl[i].ctl[2] || tbl[i].ctl[1]) exp_flush++;
    end
    @(negedge clk);
    idle();
    #1;
    chk("tbl_stall_cycles", 32'(stall_cycles), 32'(exp_stall));
    chk("tbl_flush_count", 32'(flush_count), 32'(exp_flush));

    // clear wins over a simultaneous stall + flush
    @(negedge clk);
    INS_ID_ex = INS_ID_LW; rt_ex = 5'd5; rs_id = 5'd5; clr_stats = 1'b1;
    @(negedge clk);
    idle();
    #1;
    chk("clr_stall", 32'(stall_cycles), 32'h0);
    chk("clr_flush", 32'(flush_count), 32'h0);

    // single load-use bubble from a cleared counter
    @(negedge clk);
    INS_ID_ex = INS_ID_LW; rt_ex = 5'd5; rs_id = 5'd5;
    #1;
    chk("lu_ctl", 32'(ctl_now()), 32'b0011010);
    @(negedge clk);
    idle();
    #1;
    chk("lu_stall_1", 32'(stall_cycles), 32'd1);

    // three freeze cycles, release on the fourth
    @(negedge clk);
    dmem_req = 1'b1; dmem_ready = 1'b0;
    #1;
    chk("frz1_state", 32'(state), 32'd0);
    chk("frz1_ctl", 32'(ctl_now()), 32'b0000001);
    for (int k = 2; k <= 3; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("frz%0d_state", k), 32'(state), 32'd1);
      chk($sformatf("frz%0d_ctl", k), 32'(ctl_now()), 32'b0000001);
    end
    @(negedge clk);
    dmem_ready = 1'b1;
    #1;
    chk("rel_state", 32'(state), 32'd1);
    chk("rel_ctl", 32'(ctl_now()), 32'b1111000);
    @(negedge clk);
    idle();
    #1;
    chk("post_rel_state", 32'(state), 32'd0);
    chk("short_wait_no_timeout", 32'(mem_timeout), 32'd0);
    chk("frz_stall", 32'(stall_cycles), 32'd4);

    // timeout after the 4th MEM_WAIT cycle, sticky after release
    @(negedge clk);
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("wait%0d_timeout", k), 32'(mem_timeout), 32'd0);
    end
    @(negedge clk);
    #1;
    chk("timeout_set", 32'(mem_timeout), 32'd1);
    dmem_ready = 1'b1;
    @(negedge clk);
    idle();
    #1;
    chk("timeout_state_run", 32'(state), 32'd0);
    chk("timeout_sticky", 32'(mem_timeout), 32'd1);

    // reset in the middle of a wait
    @(negedge clk);
    dmem_req = 1'b1; dmem_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_wait_state", 32'(state), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_wait_ctl", 32'(ctl_now()), 32'h0);
    @(negedge clk);
    #1;
    chk("rst_wait_state", 32'(state), 32'd0);
    chk("rst_wait_stall", 32'(stall_cycles), 32'd0);
    chk("rst_wait_flush", 32'(flush_count), 32'd0);
    chk("rst_wait_timeout", 32'(mem_timeout), 32'd0);
    chk("rst_wait_ctl2", 32'(ctl_now()), 32'h0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    #1;
    chk("after_rst_ctl", 32'(ctl_now()), 32'b1111000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
